// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Owns the HI/LO registers. The result of a mult/multu/div/divu is computed
// when the op is accepted and held in pending registers. It is committed to
// HI/LO after a fixed number of busy cycles, which models the latency of an
// iterative multiplier/divider.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        md_hold,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [31:0]     pend_hi;
  logic [31:0]     pend_lo;
  logic            pend_wr;

  // Arithmetic datapath, evaluated from the operands present on the start cycle
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division goes through magnitudes; 0x80000000 stays 0x80000000 as
  // an unsigned magnitude, which makes the -2^31 / -1 case fall out naturally.
  assign a_mag      = A[31] ? (~A + 32'd1) : A;
  assign b_mag      = B[31] ? (~B + 32'd1) : B;
  assign b_zero     = (B == 32'd0);
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_safe     = b_zero ? 32'd1 : B;

  assign q_mag = a_mag / b_mag_safe;
  assign r_mag = a_mag % b_mag_safe;
  assign q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;

  assign q_u = A / b_safe;
  assign r_u = A % b_safe;

  logic          op_valid;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_wr;
  logic [CW-1:0] res_cycles;

  // Select the result, commit enable and latency for the op being started
  always_comb begin
    op_valid   = 1'b0;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_wr     = 1'b0;
    res_cycles = CW'(MULT_CYCLES);
    case (md_op)
      OP_MULT: begin
        op_valid = 1'b1;
        res_hi   = prod_s[63:32];
        res_lo   = prod_s[31:0];
        res_wr   = 1'b1;
      end
      OP_MULTU: begin
        op_valid = 1'b1;
        res_hi   = prod_u[63:32];
        res_lo   = prod_u[31:0];
        res_wr   = 1'b1;
      end
      OP_DIV: begin
        op_valid   = 1'b1;
        res_hi     = r_s;
        res_lo     = q_s;
        res_wr     = !b_zero;
        res_cycles = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        op_valid   = 1'b1;
        res_hi     = r_u;
        res_lo     = q_u;
        res_wr     = !b_zero;
        res_cycles = CW'(DIV_CYCLES);
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

  // Control FSM: accept ops and mthi/mtlo in IDLE, count down and commit in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            count   <= res_cycles;
            busy    <= 1'b1;
            state   <= RUN;
          end else if (md_op == OP_MTHI) begin
            hi <= A;
          end else if (md_op == OP_MTLO) begin
            lo <= A;
          end
        end
        RUN: begin
          if (count == CW'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_hold = start | busy;
  assign md_out  = rd_sel ? hi : lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO registers.
- Executes mult/multu/div/divu over a fixed latency.
- Exports busy and start status, which the hazard/stall logic uses to hold later md instructions in ID.
- Handles mthi/mtlo writes and provides the mfhi/mflo read value to the EX result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; a mult/multu/div/divu is in EX this cycle.
- md_op  input  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 7 is reserved and treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- rd_sel  input  1  0 selects LO, 1 selects HI for md_out.
- busy  output  1  a calculation is in flight.
- md_hold  output  1  start | busy; the stall logic stalls any md-class instruction in ID while this is high.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_out  output  32  combinational: rd_sel ? hi : lo.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, count=0, pending regs=0. md_hold therefore equals start.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter count).
- IDLE transition: on an edge with start=1 and md_op in 1..4:
  - latch the op result into pend_hi/pend_lo;
  - load count = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4);
  - go to RUN.
- start=1 with md_op outside 1..4 is ignored.
- RUN:
  - each edge decrements count;
  - on the edge where count==1: hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
- Timing: start sampled at edge E0 → busy=1 from E0 through E0+N-1 (N = MULT_CYCLES or DIV_CYCLES) → new hi/lo visible after edge E0+N, when busy=0.
- Arithmetic:
  - mult: signed 32×32 → 64; {hi,lo} = product.
  - multu: the same, unsigned.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend A.
  - divu: unsigned quotient and remainder.
  - div by zero (B==0): hi/lo are left unchanged at commit; busy still runs the full DIV_CYCLES.
  - div of 0x80000000 by -1: lo=0x80000000, hi=0.
- mthi/mtlo: in IDLE, with md_op=5 or 6 (start is not required), hi or lo <= A on the next edge.
- While busy=1:
  - md_op=5/6 is ignored;
  - start is ignored; the current op continues unaffected.
  - The stall logic guarantees neither happens; these cases are robustness rules only.
- md_out is combinational and reflects the committed registers only. Pending values are never visible.
- Reset asserted mid-RUN: calculation aborted, busy=0 immediately, hi=lo=0, no commit after reset is released.
- Same edge as a commit: a new start cannot be accepted on the commit edge, since busy=1 during that cycle. It is accepted on the first IDLE cycle.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, start pulse → busy high exactly 5 cycles, md_hold high 6 cycles including the start cycle; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- div with B=0 after mthi 0x1234 and mtlo 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged. rd_sel toggling shows 0x1234 and 0x5678 on md_out.
- mult start, then md_op=6 (A=0xAAAA) and a second start during busy → both ignored; commit equals the first mult result and busy drops after exactly 5 cycles.
- div in flight, reset pulled low at busy cycle 4 → busy, hi, lo are 0 immediately, and no later update occurs after reset is released.
